// File: rtl/pc060ha_slave_sequencer.sv
// pc060ha_slave_sequencer
//   Drives the PC060HA slave (sound CPU) port from a request/ack command
//   interface. Each command writes the index register (SA0=0), then performs
//   one (nibble) or two (byte) data accesses (SA0=1). Byte transfers rely on
//   the chip auto-incrementing its index after every data access.
//
// Ports
//   SCLK        clock, rising edge
//   nRESET_BUF  asynchronous active-low reset; the deassertion edge is
//               expected to be SCLK-synchronous already (buffered reset)
//   nrout_i     PC060HA nROUT, asynchronous; synchronised here
//   req_i       command request, only looked at while idle
//   kind_i      00 nibble wr, 01 nibble rd, 10 byte wr, 11 byte rd
//   idx_i       register index (byte ops force idx[0]=0)
//   wdata_i     write data; byte ops send [3:0] then [7:4]
//   busy_o      command in progress (accept through ack cycle)
//   ack_o       one-cycle completion pulse
//   err_o       valid with ack: command aborted by chip reset
//   rdata_o     read result, updated at ack and held
//   nscs_o, nsrd_o, nswr_o, sa0_o, sd_o, sd_oe_o, sd_i : PC060HA slave bus
module pc060ha_slave_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic       SCLK,
    input  logic       nRESET_BUF,
    input  logic       nrout_i,
    input  logic       req_i,
    input  logic [1:0] kind_i,
    input  logic [2:0] idx_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       ack_o,
    output logic       err_o,
    output logic [7:0] rdata_o,
    output logic       nscs_o,
    output logic       nsrd_o,
    output logic       nswr_o,
    output logic       sa0_o,
    output logic [3:0] sd_o,
    output logic       sd_oe_o,
    input  logic [3:0] sd_i
);

    localparam int unsigned MaxCyc = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [CntW-1:0] StbLast = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StASet, StAStb, StAGap, StDSet, StDStb, StDGap, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      kind_q, kind_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            hi_q, hi_d;        // second (upper) nibble of a byte op
    logic [3:0]      rd_lo_q, rd_lo_d;
    logic [3:0]      rd_hi_q, rd_hi_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            nrout_s1_q, nrout_s2_q;

    logic            is_wr;
    logic [3:0]      cur_nib;

    assign is_wr   = ~kind_q[0];
    assign cur_nib = hi_q ? wdata_q[7:4] : wdata_q[3:0];

    always_ff @(posedge SCLK or negedge nRESET_BUF) begin
        if (!nRESET_BUF) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            kind_q     <= 2'b00;
            idx_q      <= 3'd0;
            wdata_q    <= 8'h00;
            hi_q       <= 1'b0;
            rd_lo_q    <= 4'h0;
            rd_hi_q    <= 4'h0;
            rdata_q    <= 8'h00;
            err_q      <= 1'b0;
            nrout_s1_q <= 1'b1;
            nrout_s2_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kind_q     <= kind_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            hi_q       <= hi_d;
            rd_lo_q    <= rd_lo_d;
            rd_hi_q    <= rd_hi_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            nrout_s1_q <= nrout_i;
            nrout_s2_q <= nrout_s1_q;
        end
    end

    // Next state and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                // Chip held in reset (nROUT low) holds off new commands.
                if (req_i && nrout_s2_q) begin
                    state_d = StASet;
                    kind_d  = kind_i;
                    idx_d   = kind_i[1] ? {idx_i[2:1], 1'b0} : idx_i;
                    wdata_d = wdata_i;
                    hi_d    = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StASet: begin
                state_d = StAStb;
                cnt_d   = '0;
            end
            StAStb: begin
                if (cnt_q == StbLast) begin
                    state_d = StAGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StDSet;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDSet: begin
                state_d = StDStb;
                cnt_d   = '0;
            end
            StDStb: begin
                if (cnt_q == StbLast) begin
                    // Read data is taken on the edge that ends the strobe.
                    if (!is_wr) begin
                        if (hi_q) rd_hi_d = sd_i;
                        else      rd_lo_d = sd_i;
                    end
                    state_d = StDGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (kind_q[1] && !hi_q) begin
                        hi_d    = 1'b1;
                        state_d = StDSet;
                    end else begin
                        state_d = StDone;
                        if (!is_wr) begin
                            rdata_d = kind_q[1] ? {rd_hi_q, rd_lo_q} : {4'h0, rd_lo_q};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Chip reset aborts any bus activity; DONE then reports the error.
        if (state_q != StIdle && state_q != StDone && !nrout_s2_q) begin
            state_d = StDone;
            err_d   = 1'b1;
            cnt_d   = '0;
            rdata_d = rdata_q;
        end
    end

    // Bus outputs decoded from state; async reset forces StIdle, which
    // releases the bus immediately.
    always_comb begin
        nscs_o  = 1'b1;
        nsrd_o  = 1'b1;
        nswr_o  = 1'b1;
        sa0_o   = 1'b0;
        sd_o    = 4'h0;
        sd_oe_o = 1'b0;
        unique case (state_q)
            StASet, StAStb: begin
                nscs_o  = 1'b0;
                sd_oe_o = 1'b1;
                sd_o    = {1'b0, idx_q};
                nswr_o  = (state_q == StAStb) ? 1'b0 : 1'b1;
            end
            StDSet, StDStb: begin
                nscs_o = 1'b0;
                sa0_o  = 1'b1;
                if (is_wr) begin
                    sd_oe_o = 1'b1;
                    sd_o    = cur_nib;
                    nswr_o  = (state_q == StDStb) ? 1'b0 : 1'b1;
                end else begin
                    nsrd_o = (state_q == StDStb) ? 1'b0 : 1'b1;
                end
            end
            // sa0 stays high through the data gap so it never moves under nscs=0.
            StDGap: sa0_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o  = (state_q != StIdle);
    assign ack_o   = (state_q == StDone);
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_pc060ha_slave_sequencer.sv
module tb_pc060ha_slave_sequencer;

    logic       SCLK = 1'b0;
    logic       nRESET_BUF = 1'b0;
    logic       nrout = 1'b1;
    logic       req = 1'b0;
    logic [1:0] kind = 2'b00;
    logic [2:0] idx = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic       busy, ack, err, nscs, nsrd, nswr, sa0, sd_oe;
    logic [7:0] rdata;
    logic [3:0] sd_o, sd_i;

    // Second instance: shortest timing, request held high continuously.
    logic       rst_f = 1'b0;
    logic       busy_f, ack_f, err_f, nscs_f, nsrd_f, nswr_f, sa0_f, sd_oe_f;
    logic [7:0] rdata_f;
    logic [3:0] sd_o_f;

    always #5 SCLK = ~SCLK;

    pc060ha_slave_sequencer dut (
        .SCLK(SCLK), .nRESET_BUF(nRESET_BUF), .nrout_i(nrout), .req_i(req),
        .kind_i(kind), .idx_i(idx), .wdata_i(wdata), .busy_o(busy), .ack_o(ack),
        .err_o(err), .rdata_o(rdata), .nscs_o(nscs), .nsrd_o(nsrd), .nswr_o(nswr),
        .sa0_o(sa0), .sd_o(sd_o), .sd_oe_o(sd_oe), .sd_i(sd_i)
    );

    pc060ha_slave_sequencer #(.STROBE_CYCLES(1), .GAP_CYCLES(1)) dut_f (
        .SCLK(SCLK), .nRESET_BUF(rst_f), .nrout_i(1'b1), .req_i(1'b1),
        .kind_i(2'b01), .idx_i(3'd1), .wdata_i(8'h00), .busy_o(busy_f), .ack_o(ack_f),
        .err_o(err_f), .rdata_o(rdata_f), .nscs_o(nscs_f), .nsrd_o(nsrd_f),
        .nswr_o(nswr_f), .sa0_o(sa0_f), .sd_o(sd_o_f), .sd_oe_o(sd_oe_f), .sd_i(4'h5)
    );

    // PC060HA slave-port model: index register with auto-increment on data access.
    logic [3:0] mts [8] = '{default: 4'h0};
    logic [3:0] stm [8] = '{4'h4, 4'hC, 4'h3, 4'h9, 4'h6, 4'h1, 4'hE, 4'hB};
    logic [2:0] midx = 3'd0;
    logic [2:0] last_idx_wr = 3'd0;
    logic       wr_pend = 1'b0, wr_sa0 = 1'b0, rd_pend = 1'b0;
    logic [3:0] wr_val = 4'h0;
    int         overlap_cnt = 0, overlap_f_cnt = 0, rd_oe_cnt = 0;

    assign sd_i = stm[midx];

    always @(negedge SCLK) begin
        if (!nswr) begin
            wr_pend <= 1'b1;
            wr_val  <= sd_o;
            wr_sa0  <= sa0;
        end else if (wr_pend) begin
            wr_pend <= 1'b0;
            if (!wr_sa0) begin
                midx        <= wr_val[2:0];
                last_idx_wr <= wr_val[2:0];
            end else begin
                mts[midx] <= wr_val;
                midx      <= midx + 3'd1;
            end
        end
        if (!nsrd) rd_pend <= 1'b1;
        else if (rd_pend) begin
            rd_pend <= 1'b0;
            midx    <= midx + 3'd1;
        end
        if (!nsrd && !nswr) overlap_cnt <= overlap_cnt + 1;
        if (!nsrd_f && !nswr_f) overlap_f_cnt <= overlap_f_cnt + 1;
        if (!nsrd && sd_oe) rd_oe_cnt <= rd_oe_cnt + 1;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge SCLK);
        while (busy && n < 50) begin
            @(negedge SCLK);
            n++;
        end
    endtask

    // Issue one command; lat = cycle number of ack after the accept edge (40 = timeout).
    task automatic run_op(input logic [1:0] k, input logic [2:0] i, input logic [7:0] w,
                          output int lat);
        wait_idle();
        req = 1'b1; kind = k; idx = i; wdata = w;
        @(posedge SCLK); #1;
        req = 1'b0;
        lat = 1;
        while (!ack && lat < 40) begin
            @(posedge SCLK); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0] kind;
        logic [2:0] idx;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] rdata;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat, cyc, oe0, acks, n;
        logic prev_b;
        int brun, irun;
        logic seen;

        vecs[0] = '{2'b00, 3'd5, 8'h01, 11, 8'h00, 3'd5};
        vecs[1] = '{2'b10, 3'd3, 8'hA7, 16, 8'h00, 3'd2};
        vecs[2] = '{2'b11, 3'd0, 8'h00, 16, 8'hC4, 3'd0};
        vecs[3] = '{2'b01, 3'd4, 8'h00, 11, 8'h06, 3'd4};
        vecs[4] = '{2'b11, 3'd7, 8'h00, 16, 8'hBE, 3'd6};
        vecs[5] = '{2'b00, 3'd2, 8'hF3, 11, 8'hBE, 3'd2};
        vecs[6] = '{2'b10, 3'd6, 8'h5C, 16, 8'hBE, 3'd6};
        vecs[7] = '{2'b01, 3'd3, 8'h00, 11, 8'h09, 3'd3};

        // Reset state.
        #12;
        check("reset_outputs",
              {busy, ack, err, nscs, nsrd, nswr, sa0, sd_oe, sd_o, rdata},
              {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00});
        @(negedge SCLK);
        nRESET_BUF = 1'b1;

        // Table of single commands against the slave model.
        for (int v = 0; v < 8; v++) begin
            oe0 = rd_oe_cnt;
            run_op(vecs[v].kind, vecs[v].idx, vecs[v].wdata, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_err", v), err, 1'b0);
            check($sformatf("v%0d_rdata", v), rdata, vecs[v].rdata);
            check($sformatf("v%0d_index_sd", v), last_idx_wr, vecs[v].exp_idx);
            if (!vecs[v].kind[0]) begin
                check($sformatf("v%0d_mts_lo", v), mts[vecs[v].exp_idx], vecs[v].wdata[3:0]);
                if (vecs[v].kind[1])
                    check($sformatf("v%0d_mts_hi", v), mts[vecs[v].exp_idx + 3'd1],
                          vecs[v].wdata[7:4]);
            end else begin
                check($sformatf("v%0d_rd_sd_oe", v), rd_oe_cnt - oe0, 0);
            end
        end

        // Chip reset during the second data strobe of a byte write.
        wait_idle();
        req = 1'b1; kind = 2'b10; idx = 3'd0; wdata = 8'h21;
        @(posedge SCLK); #1;
        req = 1'b0;
        cyc = 1;
        while (cyc < 12) begin
            @(posedge SCLK); #1;
            cyc++;
        end
        check("abort_in_second_dstb", {nswr, sa0, sd_o}, {1'b0, 1'b1, 4'h2});
        nrout = 1'b0;
        while (!ack && cyc < 40) begin
            @(posedge SCLK); #1;
            cyc++;
        end
        check("abort_ack_cycle", cyc, 15);
        check("abort_err", err, 1'b1);
        check("abort_rdata_held", rdata, 8'h09);
        check("abort_bus_released", {nswr, nsrd, nscs, sd_oe}, 4'b1110);

        // Requests held off while nROUT is low.
        wait_idle();
        req = 1'b1; kind = 2'b01; idx = 3'd4;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge SCLK); #1;
            if (busy) n++;
        end
        check("holdoff_no_accept", n, 0);
        @(negedge SCLK);
        nrout = 1'b1;
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(posedge SCLK); #1;
            cyc++;
        end
        check("holdoff_accept_edges", cyc, 3);
        req = 1'b0;
        n = 1;
        while (!ack && n < 40) begin
            @(posedge SCLK); #1;
            n++;
        end
        check("after_abort_latency", n, 11);
        check("after_abort_rdata", {err, rdata}, {1'b0, 8'h06});

        // nRESET_BUF asserted during the index strobe.
        wait_idle();
        req = 1'b1; kind = 2'b00; idx = 3'd5; wdata = 8'h0E;
        @(posedge SCLK); #1;
        req = 1'b0;
        @(posedge SCLK); #1;
        check("rst_in_astb", {nswr, nscs, sa0}, 3'b000);
        nRESET_BUF = 1'b0;
        #1;
        check("rst_release_comb", {nswr, nscs, sd_oe, busy}, 4'b1100);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge SCLK); #1;
            if (ack) n++;
        end
        check("rst_no_ack", n, 0);
        check("rst_rdata_cleared", rdata, 8'h00);
        @(negedge SCLK);
        nRESET_BUF = 1'b1;
        run_op(2'b01, 3'd4, 8'h00, lat);
        check("post_rst_latency", lat, 11);
        check("post_rst_rdata", {err, rdata}, {1'b0, 8'h06});

        // Back-to-back commands with req held high, 1-cycle strobe and gap.
        @(negedge SCLK);
        rst_f = 1'b1;
        prev_b = 1'b0; seen = 1'b0; brun = 0; irun = 0; acks = 0;
        for (int c = 0; c < 48; c++) begin
            @(posedge SCLK); #1;
            if (ack_f) acks++;
            if (busy_f) begin
                if (!prev_b) begin
                    if (seen) check("fast_idle_gap", irun, 1);
                    seen = 1'b1;
                    brun = 0;
                end
                brun++;
            end else begin
                if (prev_b) begin
                    check("fast_busy_len", brun, 7);
                    irun = 0;
                end
                irun++;
            end
            prev_b = busy_f;
        end
        check("fast_ack_count", acks >= 5, 1'b1);
        check("fast_rdata", rdata_f, 8'h05);

        check("strobe_overlap", overlap_cnt, 0);
        check("strobe_overlap_fast", overlap_f_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
